// File: rtl/vector_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : vector_load_unit
// Description : Gathers LANES words from synchronous data memory (strided or
//               scalar broadcast) and packs them into one lane-packed vector
//               operand. Lane i occupies bits [DATA_W*i +: DATA_W].
// Revision    : 1.0 - initial release
// ============================================================================
module vector_load_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      bcast,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         stride,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic                      vec_valid,
    input  logic                      vec_ready,
    output logic [LANES*DATA_W-1:0]   vec_out,
    output logic                      busy
);

    localparam int                  CNT_W       = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0]    C_LAST_LANE = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_stride;
    logic                r_bcast;
    logic [CNT_W-1:0]    r_issue_cnt;
    logic [CNT_W-1:0]    r_lane_cnt;
    logic                r_cap_pend;   // read data from last cycle's issue is on mem_rd_data
    logic                w_last_issue;

    // A broadcast needs a single read; a gather needs one per lane.
    assign w_last_issue = r_bcast ? (r_issue_cnt == '0) : (r_issue_cnt == C_LAST_LANE);
    assign busy         = (r_state != S_IDLE);

    // State register; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start only honoured in IDLE, vec_ready only in HOLD.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)        w_next_state = S_ISSUE;
            S_ISSUE: if (w_last_issue) w_next_state = S_DRAIN;
            S_DRAIN:                   w_next_state = S_HOLD;
            S_HOLD:  if (vec_ready)    w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    // Datapath: request latch, address generation, read strobe and lane capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride    <= '0;
            r_bcast     <= 1'b0;
            r_issue_cnt <= '0;
            r_lane_cnt  <= '0;
            r_cap_pend  <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            vec_valid   <= 1'b0;
            vec_out     <= '0;
        end else begin
            r_cap_pend <= mem_rd_en;

            // Memory returns data one cycle after the strobe; land it in the
            // next lane, or in every lane for a broadcast.
            if (r_cap_pend) begin
                for (int l = 0; l < LANES; l++) begin
                    if (r_bcast || (r_lane_cnt == CNT_W'(l))) begin
                        vec_out[l*DATA_W +: DATA_W] <= mem_rd_data;
                    end
                end
                r_lane_cnt <= r_lane_cnt + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_stride    <= stride;
                        r_bcast     <= bcast;
                        r_issue_cnt <= '0;
                        r_lane_cnt  <= '0;
                        mem_addr    <= base_addr;
                        mem_rd_en   <= 1'b1;
                        vec_out     <= '0;
                    end
                end
                S_ISSUE: begin
                    // Address wraps modulo 2^ADDR_W; it holds once issue ends.
                    if (w_last_issue) begin
                        mem_rd_en <= 1'b0;
                    end else begin
                        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                        mem_addr    <= mem_addr + r_stride;
                    end
                end
                S_DRAIN: begin
                    vec_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (vec_ready) begin
                        vec_valid <= 1'b0;
                    end
                end
                default: begin
                    mem_rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
